// File: rtl/product_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : product_accumulator_pkg
// Purpose  : Shared types and constants for the product accumulator slice.
// Revision : 1.0 - initial release
// ============================================================================
package product_accumulator_pkg;

    // Accumulator / result width; 256 x 0xFF = 0xFF00 always fits.
    localparam int ACC_W  = 16;
    localparam int BYTE_W = 8;

    // Byte-select values for serialising a result.
    localparam logic LO = 1'b0;
    localparam logic HI = 1'b1;

    // Block state: collecting products, or emitting the low / high byte.
    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    // Pick one byte of a result word.
    function automatic logic [BYTE_W-1:0] byte_sel(input logic [ACC_W-1:0] value,
                                                   input logic              sel);
        return (sel == HI) ? value[ACC_W-1:BYTE_W] : value[BYTE_W-1:0];
    endfunction

endpackage : product_accumulator_pkg
`default_nettype wire

// File: rtl/product_accumulator_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : byte_serializer
// Purpose  : Captures a finished 16-bit sum and emits it as two bytes,
//            low byte first, on a valid/ready handshake. Pulses o_done
//            when the high byte is taken.
// Revision : 1.0 - initial release
// ============================================================================
module byte_serializer
    import product_accumulator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ACC_W-1:0]  i_res,
    input  logic              i_ready,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_done
);

    state_t           r_state;
    state_t           w_state_next;
    logic [ACC_W-1:0] r_res;

    // State register; reset abandons any result still being sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Result holding register, loaded only when a new sum arrives while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
        end else if (i_load && (r_state == ACCUM)) begin
            r_res <= i_res;
        end
    end

    // Next-state: advance one byte per accepted transfer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (i_load)  w_state_next = SEND_LO;
            SEND_LO: if (i_ready) w_state_next = SEND_HI;
            SEND_HI: if (i_ready) w_state_next = ACCUM;
            default:              w_state_next = ACCUM;
        endcase
    end

    // Outputs depend only on state and r_res, so they hold steady under backpressure.
    always_comb begin
        o_data  = '0;
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_done  = 1'b0;
        case (r_state)
            SEND_LO: begin
                o_valid = 1'b1;
                o_data  = byte_sel(r_res, LO);
            end
            SEND_HI: begin
                o_valid = 1'b1;
                o_last  = 1'b1;
                o_data  = byte_sel(r_res, HI);
                o_done  = i_ready;
            end
            default: ;
        endcase
    end

endmodule : byte_serializer
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : product_accumulator
// Purpose  : Sums N 8-bit products into a 16-bit accumulator and hands each
//            finished sum to a byte serializer (low byte, then high byte).
//            A flush pulse closes a non-empty window early.
// Revision : 1.0 - initial release
// ============================================================================
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] prod_data,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              flush,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [7:0]        count
);

    // Index of the product that fills a window (N ranges 1..256).
    localparam logic [7:0] c_last_idx = 8'(N - 1);

    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_busy;

    logic             w_accept;
    logic             w_close;
    logic [ACC_W-1:0] w_sum;
    logic             w_done;

    assign prod_ready = ~r_busy;
    assign count      = r_cnt;

    // A flush with nothing accepted and an empty window is a no-op.
    always_comb begin
        w_accept = prod_valid & ~r_busy;
        w_sum    = r_acc + (w_accept ? ACC_W'(prod_data) : ACC_W'(0));
        w_close  = ~r_busy &
                   ((w_accept & (r_cnt == c_last_idx)) |
                    (flush & ((r_cnt != 8'd0) | w_accept)));
    end

    // Accumulator and window counter; both clear when the window closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_close) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Busy from window close until the serializer has sent the high byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else if (w_close) begin
            r_busy <= 1'b1;
        end else if (w_done) begin
            r_busy <= 1'b0;
        end
    end

    byte_serializer u_serializer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_close),
        .i_res   (w_sum),
        .i_ready (out_ready),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_last  (out_last),
        .o_done  (w_done)
    );

endmodule : product_accumulator
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_product_accumulator
// Purpose  : Directed scoreboard bench for product_accumulator (N=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] prod_data;
    logic       prod_valid;
    logic       prod_ready;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] count;

    int n_vec  = 0;
    int n_miss = 0;

    // Expected output bytes: {last, data}
    logic [8:0] exp_q[$];

    // Previous-cycle snapshot for the hold-stability check.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    always #5 clk = ~clk;

    product_accumulator #(.N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .count      (count)
    );

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_result(input logic [15:0] sum);
        exp_q.push_back({1'b0, sum[7:0]});
        exp_q.push_back({1'b1, sum[15:8]});
    endtask

    // Offer one product (optionally with flush) until it is accepted.
    task automatic send_prod(input logic [7:0] data, input logic fl);
        bit ok = 1'b0;
        prod_data  = data;
        prod_valid = 1'b1;
        flush      = fl;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (prod_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        flush      = 1'b0;
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout: product 0x%0h not accepted, expected accept within 50 cycles", data);
        end
    endtask

    // Wait until all expected bytes are gone and the block is idle again.
    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && prod_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: %0d bytes still pending, expected 0", exp_q.size());
        end
        tick();
    endtask

    // Monitor: compare every transferred byte and check hold stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 16'(out_valid), 16'd1);
                check("hold_data",  16'(out_data),  16'(prev_data));
                check("hold_last",  16'(out_last),  16'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_byte: got 0x%0h last=%0b, expected no output", out_data, out_last);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("out_data", 16'(out_data), 16'(e[7:0]));
                    check("out_last", 16'(out_last), 16'(e[8]));
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        rst        = 1'b1;
        prod_data  = 8'h00;
        prod_valid = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        repeat (3) tick();

        // Reset values
        check("rst_prod_ready", 16'(prod_ready), 16'd1);
        check("rst_out_valid",  16'(out_valid),  16'd0);
        check("rst_out_last",   16'(out_last),   16'd0);
        check("rst_out_data",   16'(out_data),   16'h00);
        check("rst_count",      16'(count),      16'd0);
        rst = 1'b0;
        tick();

        // Basic window: 0x12+0x34+0x56+0x78 = 0x0114
        push_result(16'h0114);
        send_prod(8'h12, 1'b0); check("basic_count1", 16'(count), 16'd1);
        send_prod(8'h34, 1'b0); check("basic_count2", 16'(count), 16'd2);
        send_prod(8'h56, 1'b0); check("basic_count3", 16'(count), 16'd3);
        send_prod(8'h78, 1'b0); check("basic_count0", 16'(count), 16'd0);
        check("basic_valid_k1", 16'(out_valid), 16'd1);
        check("basic_pready_k1", 16'(prod_ready), 16'd0);
        drain();

        // Max values: 4 x 0xFF = 0x03FC
        push_result(16'h03FC);
        for (int i = 0; i < 4; i++) send_prod(8'hFF, 1'b0);
        drain();

        // Backpressure with a product waiting upstream
        out_ready = 1'b0;
        push_result(16'h0114);
        send_prod(8'h12, 1'b0);
        send_prod(8'h34, 1'b0);
        send_prod(8'h56, 1'b0);
        send_prod(8'h78, 1'b0);
        prod_data  = 8'h99;
        prod_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid",      16'(out_valid),  16'd1);
            check("bp_data",       16'(out_data),   16'h14);
            check("bp_last",       16'(out_last),   16'd0);
            check("bp_prod_ready", 16'(prod_ready), 16'd0);
            check("bp_count",      16'(count),      16'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_prod(8'h99, 1'b0);
        check("bp_next_count", 16'(count), 16'd1);
        // Close the window holding 0x99 with a bare flush
        push_result(16'h0099);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("bp_flush_count", 16'(count), 16'd0);
        drain();

        // Flush after two products: 0x10+0x20 = 0x0030
        push_result(16'h0030);
        send_prod(8'h10, 1'b0);
        send_prod(8'h20, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain();

        // Flush on an empty window does nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("empty_flush_valid", 16'(out_valid),  16'd0);
            check("empty_flush_ready", 16'(prod_ready), 16'd1);
        end
        tick();

        // Simultaneous flush and accept: 0x40 + 0x05 = 0x0045
        push_result(16'h0045);
        send_prod(8'h40, 1'b0);
        send_prod(8'h05, 1'b1);
        check("simul_count", 16'(count), 16'd0);
        drain();

        // Reset while holding the high byte: 4 x 0xAA = 0x02A8, only low byte sent
        exp_q.push_back({1'b0, 8'hA8});
        for (int i = 0; i < 4; i++) send_prod(8'hAA, 1'b0);
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("abort_hi_data", 16'(out_data), 16'h02);
        check("abort_hi_last", 16'(out_last), 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid",      16'(out_valid),  16'd0);
        check("abort_prod_ready", 16'(prod_ready), 16'd1);
        check("abort_count",      16'(count),      16'd0);
        out_ready = 1'b1;
        push_result(16'h0004);
        for (int i = 0; i < 4; i++) send_prod(8'h01, 1'b0);
        drain();

        check("queue_empty", 16'(exp_q.size()), 16'd0);
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_product_accumulator
`default_nettype wire
